// File: rtl/rr_mux4way_pkg.sv
// rr_mux4way_pkg: channel indices and count shared by the collector and its arbiter
package rr_mux4way_pkg;
  localparam int NUM_CH = 4;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_mux4way_arbiter.sv
// rr_arbiter4: combinational round-robin scan starting at ptr
module rr_arbiter4
  import rr_mux4way_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic              gnt_valid,
  output logic [1:0]        gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[ptr + 2'(k)]) gnt_idx = ptr + 2'(k);
  end
endmodule

// File: rtl/rr_mux4way.sv
// rr_mux4way: registered 4-to-1 valid/ready collector with round-robin grant and source tag
module rr_mux4way
  import rr_mux4way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_sel,
  input  logic                    out_ready
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             gnt_valid, can_accept, xfer;
  logic [1:0]       gnt_idx;
  rr_arbiter4 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );
  // reset blocks acceptance so no producer sees a handshake that gets discarded
  always_comb begin
    can_accept = !out_valid_q | out_ready;
    xfer = can_accept & gnt_valid & !reset;
    in_ready = xfer ? ch_onehot(gnt_idx) : '0;
    out_valid_d = xfer ? 1'b1 : out_valid_q & !out_ready;
    out_data_d = xfer ? in_data[gnt_idx*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? gnt_idx : out_sel_q;
    ptr_d = xfer ? gnt_idx + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= CH_A;
      ptr_q <= CH_A;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_rr_mux4way.sv
// tb_rr_mux4way: directed checks of reset, grant order, backpressure, drain and mid-run reset
module tb_rr_mux4way;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [15:0] da, db, dc, dd;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  int passed = 0;
  int total = 0;
  assign in_data = {dd, dc, db, da};
  always #5 clk = ~clk;
  rr_mux4way #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_chk(input string tag, input logic v, input logic [1:0] s, input logic [15:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_sel"}, 32'(out_sel), 32'(s));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
  endtask
  initial begin
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    da = 16'h000A; db = 16'h000B; dc = 16'h000C; dd = 16'h000D;
    tick();
    tick();
    out_chk("reset", 1'b0, 2'd0, 16'h0000);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1 chk("first_grant_a", 32'(in_ready), 32'b0001);
    tick();
    out_chk("first_a", 1'b1, 2'd0, 16'h000A);
    in_valid = 4'b0100; dc = 16'h00C3;
    #1 chk("single_c_ready", 32'(in_ready), 32'b0100);
    tick();
    out_chk("single_c", 1'b1, 2'd2, 16'h00C3);
    in_valid = 4'b1111; dc = 16'h000C;
    #1 chk("d_priority", 32'(in_ready), 32'b1000);
    tick();
    out_chk("rr_d_first", 1'b1, 2'd3, 16'h000D);
    tick(); out_chk("rr0", 1'b1, 2'd0, 16'h000A);
    tick(); out_chk("rr1", 1'b1, 2'd1, 16'h000B);
    tick(); out_chk("rr2", 1'b1, 2'd2, 16'h000C);
    tick(); out_chk("rr3", 1'b1, 2'd3, 16'h000D);
    tick(); out_chk("rr4", 1'b1, 2'd0, 16'h000A);
    in_valid = 4'b0010; db = 16'h1234;
    tick();
    out_chk("bp_load_b", 1'b1, 2'd1, 16'h1234);
    out_ready = 1'b0; in_valid = 4'b0001;
    #1 chk("bp_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      out_chk("bp_hold", 1'b1, 2'd1, 16'h1234);
      chk("bp_hold_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b0001);
    tick();
    out_chk("bp_refill_a", 1'b1, 2'd0, 16'h000A);
    in_valid = 4'b0000;
    #1 chk("drain_ready", 32'(in_ready), 32'h0);
    tick();
    out_chk("drain", 1'b0, 2'd0, 16'h000A);
    tick(); tick();
    out_chk("idle", 1'b0, 2'd0, 16'h000A);
    in_valid = 4'b1101;
    #1 chk("ptr_kept_c", 32'(in_ready), 32'b0100);
    in_valid = 4'b0010; db = 16'hBEEF;
    tick();
    out_chk("after_idle_b", 1'b1, 2'd1, 16'hBEEF);
    in_valid = 4'b0101;
    #1 chk("ptr_after_b", 32'(in_ready), 32'b0100);
    out_ready = 1'b0; in_valid = 4'b1000; reset = 1'b1;
    #1 chk("mid_reset_ready", 32'(in_ready), 32'h0);
    tick();
    out_chk("mid_reset", 1'b0, 2'd0, 16'h0000);
    out_ready = 1'b1;
    #1 chk("mid_reset_ready_d", 32'(in_ready), 32'h0);
    reset = 1'b0; in_valid = 4'b1001;
    #1 chk("post_reset_a", 32'(in_ready), 32'b0001);
    tick();
    out_chk("post_reset_a_out", 1'b1, 2'd0, 16'h000A);
    chk("post_reset_d_next", 32'(in_ready), 32'b1000);
    in_valid = 4'b1000;
    tick();
    out_chk("post_reset_d_out", 1'b1, 2'd3, 16'h000D);
    in_valid = 4'b0000;
    tick();
    out_chk("final_drain", 1'b0, 2'd3, 16'h000D);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rr_mux4way.md
Name: rr_mux4way

Overview:
Registered 4-to-1 collector that merges four valid/ready input channels (a, b, c, d) into one output stream. It uses a round-robin grant.
- Each accepted word is tagged with its source index on out_sel.
- Encoding is 00=a, 01=b, 10=c, 11=d, so out_sel can drive a 4-way demultiplexer's sel directly on the return path.
- Sits between four producers and a single consumer. Sustains one word per cycle when the consumer is always ready.

Parameters:
WIDTH, 16, data word width in bits (Hack word size)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d
in_data  input  4*WIDTH  per-channel data; a=[WIDTH-1:0], b=next slice, etc.
in_ready  output  4  per-channel ready, one-hot or zero
out_valid  output  1  output register holds a word
out_data  output  WIDTH  held word
out_sel  output  2  source index of held word
out_ready  input  1  consumer accepts the word when out_valid&out_ready

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=2'b00, round-robin pointer ptr=2'b00.
- State is implicit: EMPTY (out_valid=0) or FULL (out_valid=1).
- can_accept = !out_valid | out_ready. This is combinational.
- Grant:
  - Takes the first channel i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - No valid input means no grant.
- in_ready[i] = can_accept & granted & (grant==i).
  - At most one bit is set.
  - It may depend combinationally on in_valid and out_ready.
- Transfer on channel i: in_valid[i]&in_ready[i] at the edge.
  - out_data <= in_data slice i; out_sel <= i; out_valid <= 1.
  - ptr <= i+1 mod 4, so 3 wraps to 0.
- Drain without refill: out_valid&out_ready with no grant → out_valid <= 0. out_data and out_sel keep their last values.
- Simultaneous drain and refill: the new word is loaded in the same cycle and out_valid stays 1. Throughput is 1 word/cycle.
- Stall: out_valid=1 & out_ready=0 → out_data, out_sel and ptr stay stable; in_ready=0.
- Latency: an input accepted at edge N appears on the outputs immediately after edge N. That is 1 cycle, registered, with no combinational in→out data path.
- Pointer: ptr updates only on a transfer. An idle cycle does not rotate priority.
- Fairness: with all four in_valid held high and out_ready high, grants cycle a,b,c,d,a… Each channel waits at most 3 transfers.
- Reset mid-operation: a held word is discarded (out_valid=0) and ptr returns to 00. Reset has priority over any transfer in that cycle.
- Producers must hold in_valid and data stable until accepted. The block does not check this.

Decomposition:
- Shared package:
  - Channel index constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3.
  - Channel count NUM_CH=4.
- One natural sub-module: rr_arbiter4.
  - Inputs: req[3:0], ptr.
  - Outputs: gnt_valid, gnt_idx[1:0].
  - Pure combinational priority scan.
  - The top level owns ptr, the output register and the handshake.

Test Plan:
1. Reset:
   - Stimulus: assert reset one cycle with in_valid=4'b1111 and out_ready=1.
   - Response: out_valid=0, out_data=0, out_sel=00 and in_ready=0000 after the edge. First grant after release goes to a.
2. Single channel:
   - Stimulus: in_valid=4'b0100, c data=16'h00C3, out_ready=1.
   - Response: in_ready=0100. Next cycle out_valid=1, out_data=16'h00C3, out_sel=10. ptr=11, so d has top priority next.
3. Round robin:
   - Stimulus: all valid with data a=0x000A, b=0x000B, c=0x000C, d=0x000D, out_ready=1 for 5 cycles.
   - Response: out_sel sequence 00,01,10,11,00 and out_data 0x000A,0x000B,0x000C,0x000D,0x000A, out_valid high every cycle.
4. Backpressure:
   - Stimulus: word 0x1234 from b held while out_ready=0 for 3 cycles, with a valid.
   - Response: out_data=0x1234 and out_sel=01 stable, in_ready=0000. When out_ready=1, a is loaded the same cycle (out_sel=00, out_valid stays 1).
5. Drain to empty:
   - Stimulus: one word in the register, all in_valid=0, out_ready=1.
   - Response: out_valid=0 the next cycle, ptr unchanged. An idle gap then a request from b gives out_sel=01.
6. Mid-operation reset:
   - Stimulus: out_valid=1 with out_ready=0, assert reset with in_valid=4'b1000.
   - Response: out_valid=0 and no transfer from d (in_ready[3]=0 during reset). After release, a then d follow priority from ptr=00.
